// File: rtl/reg_fifo_upsizer.sv
// Width upsizer: packs RATIO narrow valid/ready beats into one wide word, lane 0 first.
// A beat flagged in_last closes the word early; unused lanes are zero with keep bits cleared.
module reg_fifo_upsizer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]          out_keep,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int LB_RATIO = $clog2(RATIO);
    localparam int OW       = IN_WIDTH * RATIO;
    localparam logic [LB_RATIO-1:0] LAST_LANE = LB_RATIO'(RATIO - 1);

    logic [OW-1:0]       acc_q, acc_d;
    logic [RATIO-1:0]    keep_q, keep_d;
    logic [LB_RATIO-1:0] lane_q, lane_d;
    logic                done_q, done_d;
    logic [OW-1:0]       out_data_q, out_data_d;
    logic [RATIO-1:0]    out_keep_q, out_keep_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;

    logic [OW-1:0]       acc_wr_s;
    logic [RATIO-1:0]    keep_wr_s;
    logic                out_free_s;
    logic                in_fire_s;
    logic                closing_s;

    assign out_free_s = ~out_valid_q | out_ready;
    assign in_ready   = ~done_q & ((lane_q != LAST_LANE) | out_free_s);
    assign in_fire_s  = in_valid & in_ready;
    assign closing_s  = (lane_q == LAST_LANE) | in_last;

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

    // Accumulator image with the incoming beat merged into the current lane.
    always_comb begin
        acc_wr_s  = acc_q;
        keep_wr_s = keep_q;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_q == LB_RATIO'(k)) begin
                acc_wr_s[k*IN_WIDTH +: IN_WIDTH] = in_data;
                keep_wr_s[k]                     = 1'b1;
            end else begin
                acc_wr_s[k*IN_WIDTH +: IN_WIDTH] = acc_q[k*IN_WIDTH +: IN_WIDTH];
                keep_wr_s[k]                     = keep_q[k];
            end
        end
    end

    // Next-state: a held early-closed word drains before any new beat is taken.
    always_comb begin
        acc_d       = acc_q;
        keep_d      = keep_q;
        lane_d      = lane_q;
        done_d      = done_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (clear) begin
            acc_d       = {OW{1'b0}};
            keep_d      = {RATIO{1'b0}};
            lane_d      = {LB_RATIO{1'b0}};
            done_d      = 1'b0;
            out_data_d  = {OW{1'b0}};
            out_keep_d  = {RATIO{1'b0}};
            out_last_d  = 1'b0;
            out_valid_d = 1'b0;
        end else if (done_q && out_free_s) begin
            // done_q is only ever set by an in_last beat, so the word is always last
            out_data_d  = acc_q;
            out_keep_d  = keep_q;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            acc_d       = {OW{1'b0}};
            keep_d      = {RATIO{1'b0}};
            lane_d      = {LB_RATIO{1'b0}};
            done_d      = 1'b0;
        end else if (in_fire_s) begin
            if (closing_s && out_free_s) begin
                out_data_d  = acc_wr_s;
                out_keep_d  = keep_wr_s;
                out_last_d  = in_last;
                out_valid_d = 1'b1;
                acc_d       = {OW{1'b0}};
                keep_d      = {RATIO{1'b0}};
                lane_d      = {LB_RATIO{1'b0}};
            end else if (closing_s) begin
                acc_d  = acc_wr_s;
                keep_d = keep_wr_s;
                done_d = 1'b1;
            end else begin
                acc_d  = acc_wr_s;
                keep_d = keep_wr_s;
                lane_d = lane_q + LB_RATIO'(1);
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= {OW{1'b0}};
            keep_q      <= {RATIO{1'b0}};
            lane_q      <= {LB_RATIO{1'b0}};
            done_q      <= 1'b0;
            out_data_q  <= {OW{1'b0}};
            out_keep_q  <= {RATIO{1'b0}};
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            keep_q      <= keep_d;
            lane_q      <= lane_d;
            done_q      <= done_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_reg_fifo_upsizer.sv
// Table-driven bench for reg_fifo_upsizer (IN_WIDTH=8, RATIO=4): one row per clock cycle,
// expectations are the values visible during that cycle before its rising edge.
module tb_reg_fifo_upsizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        clr;
        logic        vld;
        logic        lst;
        logic [7:0]  din;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_data;
        logic [3:0]  e_keep;
        logic        e_last;
    } vec_t;

    vec_t tbl[$];

    reg_fifo_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic clr, input logic vld, input logic lst,
                                input logic [7:0] din, input logic ordy,
                                input logic e_rdy, input logic e_ov,
                                input logic [31:0] e_data, input logic [3:0] e_keep,
                                input logic e_last);
        vec_t v;
        v.clr = clr; v.vld = vld; v.lst = lst; v.din = din; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_data = e_data; v.e_keep = e_keep; v.e_last = e_last;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        clear     = v.clr;
        in_valid  = v.vld;
        in_last   = v.lst;
        in_data   = v.din;
        out_ready = v.ordy;
        #1;
        chk({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, v.e_rdy});
        chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v.e_ov});
        if (v.e_ov) begin
            chk({tag, " out_data"}, out_data, v.e_data);
            chk({tag, " out_keep"}, {28'd0, out_keep}, {28'd0, v.e_keep});
            chk({tag, " out_last"}, {31'd0, out_last}, {31'd0, v.e_last});
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " out_data"}, out_data, 32'd0);
        chk({tag, " out_keep"}, {28'd0, out_keep}, 32'd0);
        chk({tag, " out_last"}, {31'd0, out_last}, 32'd0);
    endtask

    initial begin
        // full word, back-to-back, exactly one valid cycle
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        // partial word, then single-beat last words back to back
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'hC1, 1'b1, 1'b1, 1'b1, 32'h0000BBAA, 4'h3, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'hC2, 1'b1, 1'b1, 1'b1, 32'h000000C1, 4'h1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h000000C2, 4'h1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        // backpressure: 0x01..0x08 offered with out_ready low
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h06, 1'b0, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h08, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h08070605, 4'hF, 1'b0));
        // last beat while the output is stalled
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 32'h08070605, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h08070605, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 32'h08070605, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h08070605, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h0000005A, 4'h1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0000005A, 4'h1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        // clear mid-word; the beat offered alongside clear is dropped
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h20, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 8'h99, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h30, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h31, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h32, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h33323130, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0));

        rst = 1'b1; clear = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("reset");

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // async reset with a held word and two lanes filled
        apply(mk(1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0), "ar0");
        apply(mk(1'b0, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0), "ar1");
        apply(mk(1'b0, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0), "ar2");
        apply(mk(1'b0, 1'b1, 1'b0, 8'hA4, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0), "ar3");
        apply(mk(1'b0, 1'b1, 1'b0, 8'hB1, 1'b0, 1'b1, 1'b1, 32'hA4A3A2A1, 4'hF, 1'b0), "ar4");
        apply(mk(1'b0, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b1, 32'hA4A3A2A1, 4'hF, 1'b0), "ar5");
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        // fresh word must restart at lane 0 with no leftover lanes
        apply(mk(1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0), "pr0");
        apply(mk(1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0), "pr1");
        apply(mk(1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0), "pr2");
        apply(mk(1'b0, 1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0), "pr3");
        apply(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b0), "pr4");
        apply(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0), "pr5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_fifo_upsizer.md
# reg_fifo_upsizer

Width upsizer that sits directly downstream of `reg_fifo`. It consumes narrow beats from the FIFO's out_valid/out_ready port and packs RATIO consecutive beats into one wide word, lane 0 first. A beat flagged `in_last` closes a word early; that partial word is emitted zero-padded, with a lane-keep mask. Both sides use the same valid/ready handshake as `reg_fifo`, so the block chains directly onto its output.

## Interface
- `IN_WIDTH`, default 8: width of one input beat.
- `RATIO`, default 4: input beats per output word; must be ≥ 2. `LB_RATIO = $clog2(RATIO)`.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush; discards all held data.
- `in_data`  in  IN_WIDTH  input beat (connects to FIFO `out_data`).
- `in_valid`  in  1  beat present (connects to FIFO `out_valid`).
- `in_last`  in  1  beat closes the current word.
- `in_ready`  out  1  beat accepted this cycle when high together with `in_valid` (connects to FIFO `out_ready`).
- `out_data`  out  IN_WIDTH*RATIO  packed word; lane k is bits [k*IN_WIDTH +: IN_WIDTH].
- `out_keep`  out  RATIO  bit k set means lane k holds a valid beat.
- `out_last`  out  1  word was closed by `in_last`.
- `out_valid`  out  1  output word present.
- `out_ready`  in  1  downstream accepts the word.

## Operation
- State:
  - accumulator `acc` (RATIO lanes) plus `acc_keep`.
  - lane counter `lane` (LB_RATIO bits, 0..RATIO-1).
  - `acc_done` flag: the word is complete but not yet transferred.
  - output register holding `out_data`, `out_keep`, `out_last`, `out_valid`.
- Transfer definitions:
  - `in_fire = in_valid & in_ready`.
  - `out_free = ~out_valid | out_ready`.
- `in_ready = ~acc_done & ((lane != RATIO-1) | out_free)`. It is combinational, depends on `out_ready`, and is independent of `in_data` and `in_last`.
- On `in_fire`:
  - `in_data` is written to lane `lane`, and that lane's keep bit is set.
  - If the beat is closing (`lane == RATIO-1` or `in_last`) and `out_free` is high, the word including this beat loads the output register. `out_valid` goes to 1, `out_last` takes `in_last`, the accumulator and keep bits clear, and `lane` returns to 0.
  - If the beat is closing and `out_free` is low (only possible with `in_last` at `lane < RATIO-1`), the beat is stored, `acc_done` goes to 1, and `in_ready` stays 0 until the transfer.
  - If the beat is not closing, `lane` increments.
- While `acc_done` is set and `out_free` is high, the accumulator loads the output register, `acc_done` clears, and `lane` resets to 0.
- Lanes not written in a partial word are 0 in `out_data`, and their `out_keep` bits are 0.
- The output register holds its value while `out_valid & ~out_ready`. It is not modified until it is accepted.
- `clear` (checked when `rst` is low):
  - zeroes the accumulator, keep bits, `lane`, `acc_done` and the output register in one cycle;
  - a beat offered in the same cycle is accepted but dropped;
  - `clear` takes priority over all other updates.
- `rst` asserted at any time, including mid-word or mid-stall, asynchronously forces every register to 0. Partial data is lost.

## Timing
- Reset values:
  - `out_valid = 0`, `out_data = 0`, `out_keep = 0`, `out_last = 0`.
  - `lane = 0`, `acc_done = 0`, so `in_ready = 1`.
- Latency: `out_valid` rises one cycle after the closing beat is accepted, when the output is free.
- Throughput:
  - one input beat per cycle under continuous `out_ready`;
  - one full word every RATIO cycles with no bubble between words;
  - a single-beat `in_last` word every cycle is sustained.
- Backpressure:
  - with the output stalled, RATIO-1 further beats are absorbed;
  - beat RATIO waits (`in_ready = 0`) until the cycle `out_ready` is 1, and is accepted in that same cycle.
- Simultaneous closing beat and output drain: the old word leaves, and the new word appears in the next cycle with `out_valid` continuously high.
- Word order always equals input beat order; no beat is duplicated or dropped except by `clear` or `rst`.

## Test plan
All scenarios use `IN_WIDTH = 8`, `RATIO = 4`.
- Reset: hold `rst` for 10 cycles → `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_keep = 0`.
- Full word: push 0x11, 0x22, 0x33, 0x44 on back-to-back cycles with `out_ready = 1` → one cycle after 0x44, the output shows `out_data = 0x44332211`, `out_keep = 4'hF`, `out_last = 0` for exactly one cycle.
- Partial word: push 0xAA, then 0xBB with `in_last` → `out_data = 0x0000BBAA`, `out_keep = 4'h3`, `out_last = 1`; the next word starts at lane 0.
- Backpressure: hold `out_ready = 0` and offer beats 0x01..0x08 continuously → the first word 0x04030201 is held. 0x05..0x07 are accepted, then `in_ready = 0` with 0x08 pending. After releasing `out_ready`, 0x08 is accepted that cycle, and word 0x08070605 follows with keep 4'hF.
- Last while stalled: with a word held and `out_ready = 0`, push 0x5A with `in_last` → the beat is accepted and `in_ready` then stays 0. After `out_ready = 1`, `out_data = 0x0000005A`, `out_keep = 4'h1`, `out_last = 1`, and `in_ready` returns to 1.
- Clear and reset mid-word:
  - push 0x10, 0x20, then pulse `clear`, then push 0x30..0x33 → only 0x33323130 is emitted.
  - assert `rst` asynchronously with 2 lanes filled → all outputs 0 immediately.
